// File: rtl/issue_if.sv
// Handshake and datapath signals between fetch, register file, writeback and the issue stage.
interface issue_if #(
   parameter int DATAWIDTH = 32
);
   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [31:0]          instr_i;
   logic [DATAWIDTH-1:0] pc_i;
   logic [4:0]           rs1_addr_o;
   logic [4:0]           rs2_addr_o;
   logic [DATAWIDTH-1:0] rs1_data_i;
   logic [DATAWIDTH-1:0] rs2_data_i;
   logic                 ex_valid_o;
   logic                 ex_ready_i;
   logic [3:0]           opcode_o;
   logic [DATAWIDTH-1:0] a_o;
   logic [DATAWIDTH-1:0] b_o;
   logic [DATAWIDTH-1:0] cmp_a_o;
   logic [DATAWIDTH-1:0] cmp_b_o;
   logic [4:0]           rd_o;
   logic                 wb_en_o;
   logic                 wb_valid_i;
   logic [4:0]           wb_rd_i;
   logic                 flush_i;
   logic                 illegal_o;

   // master is the issue stage itself; slave is everything around it
   modport master (
      input  in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i,
             ex_ready_i, wb_valid_i, wb_rd_i, flush_i,
      output in_ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o, opcode_o,
             a_o, b_o, cmp_a_o, cmp_b_o, rd_o, wb_en_o, illegal_o
   );

   modport slave (
      output in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i,
             ex_ready_i, wb_valid_i, wb_rd_i, flush_i,
      input  in_ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o, opcode_o,
             a_o, b_o, cmp_a_o, cmp_b_o, rd_o, wb_en_o, illegal_o
   );
endinterface

// File: rtl/issue_stage.sv
// Decode/issue stage: operand selection, RAW scoreboard and a single-entry output register
// feeding the ALU.
module issue_stage #(
   parameter int DATAWIDTH = 32,
   parameter int NREGS     = 32
) (
   input logic      clk_i,
   input logic      rst_i,
   issue_if.master  bus
);

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_MUL = 4'h2;
   localparam logic [3:0] OP_DIV = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_LW  = 4'h7;
   localparam logic [3:0] OP_SW  = 4'h8;
   localparam logic [3:0] OP_BEQ = 4'h9;
   localparam logic [3:0] OP_BGT = 4'hA;
   localparam logic [3:0] OP_BGE = 4'hB;
   localparam logic [3:0] OP_JMP = 4'hC;
   localparam logic [3:0] OP_LI  = 4'hD;

   function automatic logic signed [DATAWIDTH-1:0] sext13(input logic [12:0] v);
      return {{(DATAWIDTH-13){v[12]}}, v};
   endfunction

   logic [3:0]                  op_p0;
   logic [4:0]                  rd_p0, rs1_p0, rs2_p0;
   logic signed [DATAWIDTH-1:0] imm_p0;
   logic                        legal_p0, use1_p0, use2_p0, wb_p0;
   logic [DATAWIDTH-1:0]        a_p0, b_p0, ca_p0, cb_p0;
   logic                        haz1, haz2, hazard, in_ready, accept, handoff;

   logic                 vld_p1, illegal_p1, wb_p1;
   logic [3:0]           opcode_p1;
   logic [DATAWIDTH-1:0] a_p1, b_p1, ca_p1, cb_p1;
   logic [4:0]           rd_p1;
   logic [NREGS-1:0]     busy_q, busy_nxt;

   assign op_p0  = bus.instr_i[31:28];
   assign rd_p0  = bus.instr_i[27:23];
   assign rs1_p0 = bus.instr_i[22:18];
   assign rs2_p0 = bus.instr_i[17:13];
   assign imm_p0 = sext13(bus.instr_i[12:0]);

   assign bus.rs1_addr_o = rs1_p0;
   assign bus.rs2_addr_o = rs2_p0;

   always_comb begin
      legal_p0 = 1'b1;
      use1_p0  = 1'b0;
      use2_p0  = 1'b0;
      wb_p0    = 1'b0;
      a_p0     = '0;
      b_p0     = '0;
      ca_p0    = '0;
      cb_p0    = '0;
      case (op_p0)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR: begin
            a_p0 = bus.rs1_data_i; b_p0 = bus.rs2_data_i;
            use1_p0 = 1'b1; use2_p0 = 1'b1; wb_p0 = 1'b1;
         end
         OP_LW: begin
            a_p0 = bus.rs1_data_i; b_p0 = imm_p0;
            use1_p0 = 1'b1; wb_p0 = 1'b1;
         end
         OP_SW: begin
            a_p0 = bus.rs1_data_i; b_p0 = imm_p0; ca_p0 = bus.rs2_data_i;
            use1_p0 = 1'b1; use2_p0 = 1'b1;
         end
         OP_BEQ, OP_BGT, OP_BGE: begin
            a_p0 = bus.pc_i; b_p0 = imm_p0;
            ca_p0 = bus.rs1_data_i; cb_p0 = bus.rs2_data_i;
            use1_p0 = 1'b1; use2_p0 = 1'b1;
         end
         OP_JMP: begin
            a_p0 = bus.pc_i; b_p0 = imm_p0;
         end
         OP_LI: begin
            b_p0 = imm_p0; wb_p0 = 1'b1;
         end
         default: legal_p0 = 1'b0;
      endcase
      if (rd_p0 == 5'd0) wb_p0 = 1'b0;
   end

   // A source is blocked by the scoreboard or by the writer still sitting in the output register.
   assign haz1 = use1_p0 && (rs1_p0 != 5'd0) &&
                 (busy_q[rs1_p0] || (vld_p1 && wb_p1 && (rd_p1 == rs1_p0)));
   assign haz2 = use2_p0 && (rs2_p0 != 5'd0) &&
                 (busy_q[rs2_p0] || (vld_p1 && wb_p1 && (rd_p1 == rs2_p0)));
   assign hazard   = haz1 || haz2;
   assign in_ready = !hazard && (!vld_p1 || bus.ex_ready_i) && !bus.flush_i;
   assign accept   = bus.in_valid_i && in_ready;
   assign handoff  = vld_p1 && bus.ex_ready_i && !bus.flush_i;

   assign bus.in_ready_o = in_ready;

   // Stage p0 -> p1: output register toward execute
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p1     <= 1'b0;
         illegal_p1 <= 1'b0;
         wb_p1      <= 1'b0;
         opcode_p1  <= '0;
         a_p1       <= '0;
         b_p1       <= '0;
         ca_p1      <= '0;
         cb_p1      <= '0;
         rd_p1      <= '0;
      end else begin
         illegal_p1 <= accept && !legal_p0;
         if (bus.flush_i) begin
            vld_p1 <= 1'b0;
         end else if (accept) begin
            vld_p1 <= legal_p0;
            if (legal_p0) begin
               wb_p1     <= wb_p0;
               opcode_p1 <= op_p0;
               a_p1      <= a_p0;
               b_p1      <= b_p0;
               ca_p1     <= ca_p0;
               cb_p1     <= cb_p0;
               rd_p1     <= rd_p0;
            end
         end else if (bus.ex_ready_i) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   // Scoreboard: a set from a handoff overrides a writeback clear of the same register.
   always_comb begin
      busy_nxt = busy_q;
      if (bus.wb_valid_i && (bus.wb_rd_i != 5'd0)) busy_nxt[bus.wb_rd_i] = 1'b0;
      if (handoff && wb_p1) busy_nxt[rd_p1] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) busy_q <= '0;
      else       busy_q <= busy_nxt;
   end

   assign bus.ex_valid_o = vld_p1;
   assign bus.illegal_o  = illegal_p1;
   assign bus.opcode_o   = opcode_p1;
   assign bus.a_o        = a_p1;
   assign bus.b_o        = b_p1;
   assign bus.cmp_a_o    = ca_p1;
   assign bus.cmp_b_o    = cb_p1;
   assign bus.rd_o       = rd_p1;
   assign bus.wb_en_o    = wb_p1;

endmodule
